// File: rtl/gate_arbiter.sv
// Four-requester round-robin arbiter sharing one bitwise gate unit (AND/OR/XOR/NOT).
// Define GATE_ARB_CNT_EN to add per-requester saturating grant counters on grant_cnt.
module gate_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           req,
  input  logic [7:0]           op,
  input  logic [4*WIDTH-1:0]   a,
  input  logic [4*WIDTH-1:0]   b,
  output logic [3:0]           gnt,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [1:0]           rsp_id,
  output logic [WIDTH-1:0]     rsp_data
`ifdef GATE_ARB_CNT_EN
  ,
  output logic [31:0]          grant_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, GRANT, RESP} state_t;

  state_t           state;
  logic [1:0]       ptr;
  logic [1:0]       winner;
  logic [1:0]       pick;
  logic [1:0]       idx;
  logic             pick_valid;
  logic [1:0]       op_sel;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic [WIDTH-1:0] gate_out;

  // Round-robin search: walk offsets high to low so the one closest to ptr wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    pick       = '0;
    pick_valid = 1'b0;
    idx        = '0;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (req[idx]) begin
        pick       = idx;
        pick_valid = 1'b1;
      end
    end
  end

  // The single shared gate unit, fed from the registered winner's operand slot.
  always_comb begin
    op_sel   = op[2*winner +: 2];
    a_sel    = a[winner*WIDTH +: WIDTH];
    b_sel    = b[winner*WIDTH +: WIDTH];
    gate_out = '0;
    case (op_sel)
      2'b00: gate_out = a_sel & b_sel;
      2'b01: gate_out = a_sel | b_sel;
      2'b10: gate_out = a_sel ^ b_sel;
      2'b11: gate_out = ~a_sel;
      default: gate_out = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      winner    <= '0;
      gnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            winner <= pick;
            gnt    <= 4'b0001 << pick;
            ptr    <= pick + 2'd1;
            state  <= GRANT;
          end
        end
        GRANT: begin
          gnt       <= '0;
          rsp_valid <= 1'b1;
          rsp_id    <= winner;
          rsp_data  <= gate_out;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GATE_ARB_CNT_EN
  logic [7:0] cnt [4];

  // NOTE: the counter array is small and must read 0 after reset, so it is reset explicitly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else if (state == IDLE && pick_valid && cnt[pick] != 8'hFF) begin
      cnt[pick] <= cnt[pick] + 8'd1;
    end
  end

  assign grant_cnt = {cnt[3], cnt[2], cnt[1], cnt[0]};
`endif

endmodule

// File: tb/tb_gate_arbiter.sv
// Self-checking bench for gate_arbiter: spec vectors, fairness, backpressure, reset and random traffic.
// Build with GATE_ARB_CNT_EN defined to also exercise grant_cnt saturation.
module tb_gate_arbiter;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     req;
  logic [7:0]     op;
  logic [4*W-1:0] a;
  logic [4*W-1:0] b;
  logic [3:0]     gnt;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_data;
`ifdef GATE_ARB_CNT_EN
  logic [31:0]    grant_cnt;
`endif

  int vectors    = 0;
  int miscompares = 0;
  int m_ptr      = 0;

  gate_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .a(a), .b(b),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data)
`ifdef GATE_ARB_CNT_EN
    , .grant_cnt(grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    int         id;
    logic [3:0] data;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: first requester at or after the pointer, wrapping 3 -> 0.
  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int i = 0; i < 4; i++)
      if (r[(p + i) % 4]) return (p + i) % 4;
    return -1;
  endfunction

  function automatic logic [3:0] gate_ref(input logic [1:0] o, input logic [3:0] x, input logic [3:0] y);
    case (o)
      2'b00: return x & y;
      2'b01: return x | y;
      2'b10: return x ^ y;
      default: return ~x;
    endcase
  endfunction

  // One full transaction starting from IDLE at a negedge; ends back in IDLE at a negedge.
  task automatic run_txn(input logic [3:0] r, input logic [7:0] o, input logic [15:0] aa,
                         input logic [15:0] bb, input int exp_id, input logic [3:0] exp_d,
                         input int hold);
    req = r; op = o; a = aa; b = bb;
    rsp_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("gnt", {28'd0, gnt}, 32'(1) << exp_id);
    check("valid_in_grant", {31'd0, rsp_valid}, 32'd0);
    rsp_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("gnt_after_grant", {28'd0, gnt}, 32'd0);
    check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("rsp_id", {30'd0, rsp_id}, 32'(exp_id));
    check("rsp_data", {28'd0, rsp_data}, {28'd0, exp_d});
    op = 8'($urandom); a = 16'($urandom); b = 16'($urandom);
    for (int h = 0; h < hold; h++) begin
      rsp_ready = 1'b0;
      @(negedge clk);
      check("hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold_id", {30'd0, rsp_id}, 32'(exp_id));
      check("hold_data", {28'd0, rsp_data}, {28'd0, exp_d});
      check("hold_no_gnt", {28'd0, gnt}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("valid_after_ack", {31'd0, rsp_valid}, 32'd0);
    check("gnt_after_ack", {28'd0, gnt}, 32'd0);
    req = 4'd0; rsp_ready = 1'b0;
    m_ptr = (exp_id + 1) % 4;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"}, {28'd0, gnt}, 32'd0);
    check({tag, "_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_id"}, {30'd0, rsp_id}, 32'd0);
    check({tag, "_data"}, {28'd0, rsp_data}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0; req = 4'd0; rsp_ready = 1'b0;
    m_ptr = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    logic [7:0]  o;
    logic [15:0] aa, bb;
    logic [3:0]  r;
    int          id;

    vecs[0] = '{4'b0001, 2'b00, 4'b1100, 4'b1010, 0, 4'b1000};
    vecs[1] = '{4'b0100, 2'b00, 4'b1100, 4'b1010, 2, 4'b1000};
    vecs[2] = '{4'b0100, 2'b01, 4'b1100, 4'b1010, 2, 4'b1110};
    vecs[3] = '{4'b0100, 2'b10, 4'b1100, 4'b1010, 2, 4'b0110};
    vecs[4] = '{4'b0100, 2'b11, 4'b1100, 4'b1010, 2, 4'b0011};
    vecs[5] = '{4'b1000, 2'b10, 4'b1111, 4'b0101, 3, 4'b1010};
    vecs[6] = '{4'b0010, 2'b11, 4'b0000, 4'b1111, 1, 4'b1111};

    rst = 1'b1; req = '0; op = '0; a = '0; b = '0; rsp_ready = 1'b0;
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b0;

    // Spec vectors; the first one also shows the first edge after reset accepts a request.
    for (int v = 0; v < 7; v++) begin
      o = 8'($urandom); aa = 16'($urandom); bb = 16'($urandom);
      o[2*vecs[v].id +: 2]  = vecs[v].op;
      aa[4*vecs[v].id +: 4] = vecs[v].a;
      bb[4*vecs[v].id +: 4] = vecs[v].b;
      run_txn(vecs[v].req, o, aa, bb, vecs[v].id, vecs[v].data, 0);
    end

    // Fairness with all requests held and the consumer always ready.
    do_reset();
    o = 8'($urandom); aa = 16'($urandom); bb = 16'($urandom);
    req = 4'hF; op = o; a = aa; b = bb; rsp_ready = 1'b1;
    for (int g = 0; g < 6; g++) begin
      int waited;
      id = rr_pick(4'hF, m_ptr);
      waited = 0;
      @(negedge clk);
      while (gnt == 4'd0 && waited < 6) begin
        @(negedge clk);
        waited++;
      end
      check("fair_gnt", {28'd0, gnt}, 32'(1) << id);
      check("fair_order", 32'(id), 32'(g % 4));
      m_ptr = (id + 1) % 4;
      @(negedge clk);
      check("fair_id", {30'd0, rsp_id}, 32'(id));
      check("fair_data", {28'd0, rsp_data}, {28'd0, gate_ref(o[2*id +: 2], aa[4*id +: 4], bb[4*id +: 4])});
    end
    req = 4'd0;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Backpressure: five stalled cycles with every other requester still asserting.
    do_reset();
    o = 8'($urandom); aa = 16'($urandom); bb = 16'($urandom);
    run_txn(4'b1011, o, aa, bb, 0, gate_ref(o[1:0], aa[3:0], bb[3:0]), 5);
    o = 8'($urandom); aa = 16'($urandom); bb = 16'($urandom);
    run_txn(4'b1011, o, aa, bb, 1, gate_ref(o[3:2], aa[7:4], bb[7:4]), 0);

    // Reset in RESP, then in GRANT: transaction is abandoned.
    for (int phase = 0; phase < 2; phase++) begin
      req = 4'b1000; op = 8'hFF; a = 16'hFFFF; b = 16'h0000; rsp_ready = 1'b0;
      @(negedge clk);
      if (phase == 0) @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      check_reset_outputs(phase == 0 ? "rst_resp" : "rst_grant");
      @(negedge clk);
      rst = 1'b0; req = 4'd0; m_ptr = 0;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        check("post_rst_valid", {31'd0, rsp_valid}, 32'd0);
        check("post_rst_gnt", {28'd0, gnt}, 32'd0);
      end
    end

    // Random traffic against the reference model.
    for (int t = 0; t < 60; t++) begin
      r = 4'($urandom_range(0, 15));
      o = 8'($urandom); aa = 16'($urandom); bb = 16'($urandom);
      if (r == 4'd0) begin
        req = 4'd0; rsp_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("idle_gnt", {28'd0, gnt}, 32'd0);
        check("idle_valid", {31'd0, rsp_valid}, 32'd0);
      end else begin
        id = rr_pick(r, m_ptr);
        run_txn(r, o, aa, bb, id, gate_ref(o[2*id +: 2], aa[4*id +: 4], bb[4*id +: 4]),
                $urandom_range(0, 3));
      end
    end

`ifdef GATE_ARB_CNT_EN
    do_reset();
    check("cnt_reset", grant_cnt, 32'd0);
    for (int n = 0; n < 300; n++) begin
      o = 8'($urandom); aa = 16'($urandom); bb = 16'($urandom);
      run_txn(4'b0010, o, aa, bb, 1, gate_ref(o[3:2], aa[7:4], bb[7:4]), 0);
      if (n == 9) check("cnt_10", grant_cnt, 32'h0000_0A00);
    end
    check("cnt_sat", grant_cnt, 32'h0000_FF00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
